// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin uart_tx arbiter.
package uart_tx_arb_pkg;

    localparam int unsigned UART_NUMB_BIT_MAX    = 8;
    localparam int unsigned UART_ARB_FSM_WD      = 3;
    localparam int unsigned UART_ARB_NUM_REQ_MAX = 8;

    typedef enum logic [UART_ARB_FSM_WD-1:0] {
        ARB_IDLE      = 3'd0,
        ARB_ISSUE     = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping at NUM_REQ-1.
module uart_tx_arb_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_ID_WD = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [REQ_ID_WD-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [REQ_ID_WD-1:0] gnt_id_o,
    output logic                 any_o
);

    localparam int unsigned IDX_WD = REQ_ID_WD + 1;

    // Walk NUM_REQ positions starting at ptr; the extra index bit covers ptr+k before wrapping.
    always_comb begin
        logic [IDX_WD-1:0] idx;
        logic              found;
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_WD'(ptr_i) + IDX_WD'(k);
            if (idx >= IDX_WD'(NUM_REQ)) begin
                idx = idx - IDX_WD'(NUM_REQ);
            end
            if (!found && req_i[idx[REQ_ID_WD-1:0]]) begin
                found                       = 1'b1;
                gnt_id_o                    = idx[REQ_ID_WD-1:0];
                gnt_o[idx[REQ_ID_WD-1:0]]   = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx serializer between NUM_REQ requesters.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_ID_WD = 2,
    parameter int unsigned DAT_WD    = UART_NUMB_BIT_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_val_i,
    input  logic [NUM_REQ*DAT_WD-1:0]   req_dat_i,
    output logic [NUM_REQ-1:0]          req_rdy_o,
    output logic                        tx_val_o,
    output logic [DAT_WD-1:0]           tx_dat_o,
    input  logic                        tx_ready_i,
    output logic [REQ_ID_WD-1:0]        gnt_id_o,
    output logic                        done_o,
    output logic                        busy_o
);

    localparam int unsigned PTR_WD = REQ_ID_WD + 1;

    arb_state_e             state_q, state_d;
    logic [REQ_ID_WD-1:0]   ptr_q, ptr_d;
    logic [REQ_ID_WD-1:0]   gnt_id_q, gnt_id_d;
    logic [DAT_WD-1:0]      dat_q, dat_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [REQ_ID_WD-1:0]   pick_id;
    logic                   pick_any;
    logic [DAT_WD-1:0]      pick_dat;
    logic [PTR_WD-1:0]      ptr_nxt;

    uart_tx_arb_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .REQ_ID_WD (REQ_ID_WD)
    ) u_rr_pick (
        .req_i    (req_val_i),
        .ptr_i    (ptr_q),
        .gnt_o    (pick_gnt),
        .gnt_id_o (pick_id),
        .any_o    (pick_any)
    );

    // Winner's data lane.
    always_comb begin
        pick_dat = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_dat = req_dat_i[i*DAT_WD +: DAT_WD];
            end
        end
    end

    // Pointer moves one past the finished owner, wrapping at NUM_REQ.
    always_comb begin
        ptr_nxt = PTR_WD'(gnt_id_q) + PTR_WD'(1);
        if (ptr_nxt >= PTR_WD'(NUM_REQ)) begin
            ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        dat_d     = dat_q;
        req_rdy_o = '0;
        done_o    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (tx_ready_i && pick_any) begin
                    req_rdy_o = pick_gnt;
                    dat_d     = pick_dat;
                    gnt_id_d  = pick_id;
                    state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (!tx_ready_i) begin
                    state_d = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_ready_i) begin
                    done_o  = 1'b1;
                    ptr_d   = ptr_nxt[REQ_ID_WD-1:0];
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        // Hold handshake and completion quiet while reset is asserted.
        if (rst) begin
            req_rdy_o = '0;
            done_o    = 1'b0;
        end
    end

    assign tx_val_o = (state_q == ARB_ISSUE);
    assign busy_o   = (state_q != ARB_IDLE);
    assign tx_dat_o = dat_q;
    assign gnt_id_o = gnt_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb driving a behavioural 8N1 uart_tx model (div 3).
module tb_uart_tx_arb;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned DIV = 3;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] dat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_val = '0;
    logic [DW-1:0]     dat_arr [NR];
    logic [NR*DW-1:0]  req_dat;
    logic [NR-1:0]     req_rdy_o;
    logic              tx_val_o;
    logic [DW-1:0]     tx_dat_o;
    logic              tx_ready;
    logic [1:0]        gnt_id_o;
    logic              done_o;
    logic              busy_o;
    logic              stall = 1'b0;

    logic              mdl_ready = 1'b1;
    logic [3:0]        bit_idx = '0;
    logic [1:0]        div_cnt = '0;
    logic              line;

    exp_t              exp_q [$];
    int                rem [NR];
    int                total = 0;
    int                bad = 0;
    int                done_cnt = 0;
    int                tmo_cnt = 0;
    int                tmo_ack = 0;
    logic              end_req = 1'b0;
    logic              end_ack = 1'b0;

    logic              in_frame = 1'b0;
    logic              hs_prev = 1'b0;
    logic              seen_busy = 1'b0;
    logic              rst_prev = 1'b0;
    logic [DW-1:0]     cur_dat = '0;
    logic [DW-1:0]     rx_byte = '0;

    always #5 clk = ~clk;

    assign req_dat  = {dat_arr[3], dat_arr[2], dat_arr[1], dat_arr[0]};
    assign tx_ready = mdl_ready & ~stall;

    uart_tx_arb #(
        .NUM_REQ   (NR),
        .REQ_ID_WD (2),
        .DAT_WD    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val_i  (req_val),
        .req_dat_i  (req_dat),
        .req_rdy_o  (req_rdy_o),
        .tx_val_o   (tx_val_o),
        .tx_dat_o   (tx_dat_o),
        .tx_ready_i (tx_ready),
        .gnt_id_o   (gnt_id_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    // uart_tx stand-in: start bit, 8 data bits LSB first read live from tx_dat_o, stop bit.
    always @(posedge clk) begin
        if (rst) begin
            mdl_ready <= 1'b1;
            bit_idx   <= '0;
            div_cnt   <= '0;
        end else if (mdl_ready) begin
            if (tx_val_o && !stall) begin
                mdl_ready <= 1'b0;
                bit_idx   <= '0;
                div_cnt   <= '0;
            end
        end else if (div_cnt == 2'(DIV - 1)) begin
            div_cnt <= '0;
            if (bit_idx == 4'd9) mdl_ready <= 1'b1;
            else                 bit_idx   <= bit_idx + 4'd1;
        end else begin
            div_cnt <= div_cnt + 2'd1;
        end
    end

    assign line = mdl_ready ? 1'b1 :
                  (bit_idx == 4'd0) ? 1'b0 :
                  (bit_idx <= 4'd8) ? tx_dat_o[3'(bit_idx - 4'd1)] : 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on each tx_val_o pulse.
    always @(negedge clk) begin
        exp_t e;
        if (tmo_cnt != tmo_ack) begin
            total++;
            bad++;
            tmo_ack = tmo_cnt;
        end
        if (rst) begin
            if (rst_prev) begin
                chk("rst_req_rdy", 32'(req_rdy_o), 0);
                chk("rst_tx_val",  32'(tx_val_o),  0);
                chk("rst_tx_dat",  32'(tx_dat_o),  0);
                chk("rst_gnt_id",  32'(gnt_id_o),  0);
                chk("rst_done",    32'(done_o),    0);
                chk("rst_busy",    32'(busy_o),    0);
            end
            rst_prev  = 1'b1;
            in_frame  = 1'b0;
            hs_prev   = 1'b0;
            seen_busy = 1'b0;
            rx_byte   = '0;
        end else begin
            rst_prev = 1'b0;
            chk("busy", 32'(busy_o), 32'(in_frame));
            if (!in_frame && tx_ready && |req_val) begin
                chk("rdy_onehot", 32'($onehot(req_rdy_o)), 1);
                chk("rdy_in_val", 32'(req_rdy_o & ~req_val), 0);
            end else begin
                chk("rdy_quiet", 32'(req_rdy_o), 0);
            end
            chk("tx_val_lat", 32'(tx_val_o), 32'(hs_prev));
            if (tx_val_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_val", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_id", 32'(gnt_id_o), 32'(e.id));
                    chk("tx_dat", 32'(tx_dat_o), 32'(e.dat));
                    cur_dat = e.dat;
                    rx_byte = '0;
                end
            end
            if (!mdl_ready && div_cnt == 2'd1 && bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
                rx_byte[3'(bit_idx - 4'd1)] = line;
            end
            chk("done", 32'(done_o), 32'(in_frame && seen_busy && tx_ready));
            if (in_frame && !tx_ready) seen_busy = 1'b1;
            if (done_o) begin
                chk("line_byte", 32'(rx_byte), 32'(cur_dat));
                chk("tx_dat_hold", 32'(tx_dat_o), 32'(cur_dat));
                in_frame = 1'b0;
                done_cnt++;
            end
            hs_prev = |(req_rdy_o & req_val);
            if (hs_prev) begin
                in_frame  = 1'b1;
                seen_busy = 1'b0;
            end
        end
        if (end_req && !end_ack) begin
            chk("queue_empty", 32'(exp_q.size()), 0);
            end_ack = 1'b1;
        end
    end

    // One clock: note handshakes, then retire or refresh the accepted requesters.
    task automatic step();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = req_val & req_rdy_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NR); i++) begin
            if (hs[i]) begin
                rem[i]--;
                if (rem[i] <= 0) req_val[i] = 1'b0;
                else             dat_arr[i] = dat_arr[i] + 8'h11;
            end
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic post(input int id, input logic [DW-1:0] d, input int cnt);
        dat_arr[id] = d;
        rem[id]     = cnt;
        req_val[id] = 1'b1;
    endtask

    task automatic expect_frame(input logic [1:0] id, input logic [DW-1:0] d);
        exp_t e;
        e.id  = id;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic run_frames(input int n, input string tag);
        int target;
        int budget;
        target = done_cnt + n;
        budget = 40 * n + 50;
        while (done_cnt < target && budget > 0) begin
            step();
            budget--;
        end
        if (done_cnt < target) begin
            $display("FAIL timeout_%s: got %0d frames expected %0d", tag, done_cnt, target);
            tmo_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_n(2);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < int'(NR); i++) begin
            dat_arr[i] = '0;
            rem[i]     = 0;
        end
        rst = 1'b1;
        step_n(3);
        rst = 1'b0;

        // single request from requester 0
        post(0, 8'h55, 1);
        expect_frame(2'd0, 8'h55);
        run_frames(1, "single");
        step();

        // all requesters held from ptr 0: order 0,1,2,3,0
        do_reset();
        post(0, 8'hA0, 2);
        post(1, 8'h11, 1);
        post(2, 8'h22, 1);
        post(3, 8'h33, 1);
        expect_frame(2'd0, 8'hA0);
        expect_frame(2'd1, 8'h11);
        expect_frame(2'd2, 8'h22);
        expect_frame(2'd3, 8'h33);
        expect_frame(2'd0, 8'hB1);
        run_frames(5, "all_held");
        step();

        // requester 2 arrives while frame of requester 0 is in flight (ptr 1)
        post(0, 8'h0C, 1);
        expect_frame(2'd0, 8'h0C);
        step_n(12);
        post(2, 8'h2E, 1);
        expect_frame(2'd2, 8'h2E);
        run_frames(2, "busy_req");
        step();

        // ptr 3 with requesters 1 and 3: 3 first, then wrap to 1
        post(1, 8'h71, 1);
        post(3, 8'h93, 1);
        expect_frame(2'd3, 8'h93);
        expect_frame(2'd1, 8'h71);
        run_frames(2, "wrap");
        step();

        // reset mid-frame, then ptr must restart at 0 (1 before 3)
        post(1, 8'h4B, 1);
        expect_frame(2'd1, 8'h4B);
        step_n(15);
        do_reset();
        post(1, 8'h1D, 1);
        post(3, 8'h3F, 1);
        expect_frame(2'd1, 8'h1D);
        expect_frame(2'd3, 8'h3F);
        run_frames(2, "after_reset");
        step();

        // uart_tx not ready: no grant until it becomes ready
        stall = 1'b1;
        post(0, 8'h66, 1);
        expect_frame(2'd0, 8'h66);
        step_n(8);
        stall = 1'b0;
        run_frames(1, "stall");
        step_n(2);

        end_req = 1'b1;
        guard = 0;
        while (!end_ack && guard < 5) begin
            step();
            guard++;
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
